periodic_ctrl: RTL and testbench

- Bus-facing controller that configures and sequences NUM_CH periodic square-wave channels.
- Channels share one 16-bit data_in bus and each has its own set_latch, set_count and enable strobes.
- Holds shadow period registers, a channel enable mask and a programmable prescaler that generates the shared enable tick.
- Runs a restart sequence that reloads every channel's counter with enable ticks suppressed, so all channels restart phase-aligned.

---
 rtl/periodic_pkg.sv | 19 +
 rtl/periodic_ctrl_if.sv | 12 +
 rtl/periodic_prescaler.sv | 30 +++
 rtl/periodic_ctrl.sv | 137 +++++++++++++
 tb/tb_periodic_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/periodic_pkg.sv
// Shared address map, command bit positions and restart-sequencer states for periodic_ctrl.
package periodic_pkg;

    localparam logic [3:0] ADDR_MASK   = 4'h8;
    localparam logic [3:0] ADDR_PRE_LO = 4'h9;
    localparam logic [3:0] ADDR_PRE_HI = 4'hA;
    localparam logic [3:0] ADDR_CMD    = 4'hB;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int CMD_RESTART   = 0;
    localparam int CMD_PRESC_CLR = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEQ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/periodic_ctrl_if.sv
// Register write/read bus of periodic_ctrl; writes complete when wr && wr_ready.
interface periodic_ctrl_if;
    logic       wr;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    modport master (output wr, wr_addr, wr_data, rd_addr, input wr_ready, rd_data);
    modport slave  (input wr, wr_addr, wr_data, rd_addr, output wr_ready, rd_data);
endinterface

// File: rtl/periodic_prescaler.sv
// Down-counting prescaler producing the shared enable tick; tick is combinational from the count.
// clr reloads the count without a tick; hold freezes it (clr takes priority).
module periodic_prescaler #(
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] prescale,
    input  logic        clr,
    input  logic        hold,
    output logic        tick
);
    logic [15:0] cnt;

    assign tick = (cnt == 16'd0) && !clr && !hold;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= PRESCALE_RESET;
        end else if (clr) begin
            cnt <= prescale;
        end else if (hold) begin
            cnt <= cnt;
        end else if (cnt == 16'd0) begin
            cnt <= prescale;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end
endmodule

// File: rtl/periodic_ctrl.sv
// Register front-end and restart sequencer for NUM_CH periodic channels; strobes registered, 1 cycle after the write.
// wr_ready drops for the whole restart sequence; the master must hold wr until it returns.
module periodic_ctrl
    import periodic_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic              clock,
    input  logic              reset_n,
    periodic_ctrl_if.slave    bus,
    output logic [15:0]       ch_data,
    output logic [NUM_CH-1:0] ch_set_latch,
    output logic [NUM_CH-1:0] ch_set_count,
    output logic [NUM_CH-1:0] ch_enable
);
    state_t            state, state_nxt;
    logic [1:0]        seq_idx, seq_idx_nxt;
    logic [15:0]       data_nxt;
    logic [NUM_CH-1:0] latch_nxt, count_nxt;

    logic [15:0]       shadow [4];
    logic [7:0]        staging;
    logic [NUM_CH-1:0] mask;
    logic [15:0]       prescale;

    logic              busy, accept, tick, presc_clr;
    logic [1:0]        wr_ch, rd_ch;
    logic              wr_is_ch, commit_ch, restart;

    assign busy         = (state != ST_IDLE);
    assign bus.wr_ready = !busy;
    assign accept       = bus.wr && !busy;

    assign wr_ch     = bus.wr_addr[2:1];
    assign wr_is_ch  = !bus.wr_addr[3];
    assign commit_ch = accept && wr_is_ch && bus.wr_addr[0] && (int'(wr_ch) < NUM_CH);
    assign restart   = accept && (bus.wr_addr == ADDR_CMD) && bus.wr_data[CMD_RESTART];
    // A restart ends in DONE with its own reload, so a simultaneous clear is dropped.
    assign presc_clr = accept && (bus.wr_addr == ADDR_CMD) && bus.wr_data[CMD_PRESC_CLR]
                       && !bus.wr_data[CMD_RESTART];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 4; n++) shadow[n] <= '0;
            staging  <= '0;
            mask     <= '0;
            prescale <= PRESCALE_RESET;
        end else if (accept) begin
            if ((wr_is_ch && !bus.wr_addr[0]) || (bus.wr_addr == ADDR_PRE_LO))
                staging <= bus.wr_data;
            if (commit_ch)
                shadow[wr_ch] <= {bus.wr_data, staging};
            if (bus.wr_addr == ADDR_MASK)
                mask <= bus.wr_data[NUM_CH-1:0];
            if (bus.wr_addr == ADDR_PRE_HI)
                prescale <= {bus.wr_data, staging};
        end
    end

    always_comb begin
        state_nxt   = state;
        seq_idx_nxt = seq_idx;
        data_nxt    = ch_data;
        latch_nxt   = '0;
        count_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (commit_ch) begin
                    data_nxt = {bus.wr_data, staging};
                    for (int n = 0; n < NUM_CH; n++) latch_nxt[n] = (wr_ch == 2'(n));
                end else if (restart) begin
                    state_nxt    = ST_SEQ;
                    seq_idx_nxt  = 2'd0;
                    data_nxt     = shadow[0];
                    count_nxt[0] = 1'b1;
                end
            end
            ST_SEQ: begin
                if (int'(seq_idx) == NUM_CH - 1) begin
                    state_nxt = ST_DONE;
                end else begin
                    seq_idx_nxt = seq_idx + 2'd1;
                    data_nxt    = shadow[seq_idx_nxt];
                    for (int n = 0; n < NUM_CH; n++) count_nxt[n] = (seq_idx_nxt == 2'(n));
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            seq_idx      <= '0;
            ch_data      <= '0;
            ch_set_latch <= '0;
            ch_set_count <= '0;
        end else begin
            state        <= state_nxt;
            seq_idx      <= seq_idx_nxt;
            ch_data      <= data_nxt;
            ch_set_latch <= latch_nxt;
            ch_set_count <= count_nxt;
        end
    end

    // Counter frozen while sequencing, then reloaded in DONE so all channels share the first tick.
    periodic_prescaler #(.PRESCALE_RESET(PRESCALE_RESET)) u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .prescale (prescale),
        .clr      (presc_clr || (state == ST_DONE)),
        .hold     (busy),
        .tick     (tick)
    );

    assign ch_enable = (tick && !busy) ? mask : '0;

    assign rd_ch = bus.rd_addr[2:1];
    always_comb begin
        bus.rd_data = '0;
        if (!bus.rd_addr[3]) begin
            if (int'(rd_ch) < NUM_CH)
                bus.rd_data = bus.rd_addr[0] ? shadow[rd_ch][15:8] : shadow[rd_ch][7:0];
        end else begin
            case (bus.rd_addr)
                ADDR_MASK:   bus.rd_data[NUM_CH-1:0] = mask;
                ADDR_PRE_LO: bus.rd_data = prescale[7:0];
                ADDR_PRE_HI: bus.rd_data = prescale[15:8];
                ADDR_STATUS: bus.rd_data = {7'd0, busy};
                default:     bus.rd_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_periodic_ctrl.sv
// Directed bench for periodic_ctrl: a 4-channel instance plus a 2-channel instance for out-of-range channels.
module tb_periodic_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    periodic_ctrl_if bus ();
    periodic_ctrl_if bus2 ();

    logic [15:0] ch_data, ch_data2;
    logic [3:0]  ch_set_latch, ch_set_count, ch_enable;
    logic [1:0]  ch_set_latch2, ch_set_count2, ch_enable2;

    periodic_ctrl #(.NUM_CH(4), .PRESCALE_RESET(16'd0)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave),
        .ch_data(ch_data), .ch_set_latch(ch_set_latch),
        .ch_set_count(ch_set_count), .ch_enable(ch_enable)
    );

    periodic_ctrl #(.NUM_CH(2), .PRESCALE_RESET(16'd0)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2.slave),
        .ch_data(ch_data2), .ch_set_latch(ch_set_latch2),
        .ch_set_count(ch_set_count2), .ch_enable(ch_enable2)
    );

    int vecs  = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [7:0] d);
        bus.wr = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic wr2(input logic [3:0] a, input logic [7:0] d);
        bus2.wr = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
        step();
        bus2.wr = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        #1;
        check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    initial begin
        int n;
        int latch_seen;
        bus.wr = 0;  bus.wr_addr = 0;  bus.wr_data = 0;  bus.rd_addr = 0;
        bus2.wr = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.rd_addr = 0;

        // Reset state
        step(); step();
        check("rst_ch_data", 32'(ch_data), 32'h0);
        check("rst_latch", 32'(ch_set_latch), 32'h0);
        check("rst_count", 32'(ch_set_count), 32'h0);
        check("rst_ready", 32'(bus.wr_ready), 32'h1);
        check("rst_enable", 32'(ch_enable), 32'h0);
        rd1("rst_status", 4'hC, 8'h00);
        @(posedge clock); #1 reset_n = 1'b1;
        step();

        // Period commit on channel 0
        wr1(4'h0, 8'h34);
        check("lo_no_latch", 32'(ch_set_latch), 32'h0);
        wr1(4'h1, 8'h12);
        check("commit_data", 32'(ch_data), 32'h1234);
        check("commit_latch", 32'(ch_set_latch), 32'h1);
        step();
        check("latch_1cyc", 32'(ch_set_latch), 32'h0);
        check("data_held", 32'(ch_data), 32'h1234);
        rd1("rd_sh0_lo", 4'h0, 8'h34);
        rd1("rd_sh0_hi", 4'h1, 8'h12);

        // Prescale 3, mask 0101, phase fixed by PRESC_CLR
        wr1(4'h9, 8'h03);
        wr1(4'hA, 8'h00);
        wr1(4'h8, 8'h05);
        rd1("rd_pre_lo", 4'h9, 8'h03);
        rd1("rd_mask", 4'h8, 8'h05);
        wr1(4'hB, 8'h02);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("presc_en_%0d", k), 32'(ch_enable), (k == 3 || k == 7) ? 32'h5 : 32'h0);
            step();
        end

        // Restart sequence (RESTART together with PRESC_CLR)
        wr1(4'h0, 8'h10); wr1(4'h1, 8'h00);
        wr1(4'h2, 8'h20); wr1(4'h3, 8'h00);
        wr1(4'h4, 8'h30); wr1(4'h5, 8'h00);
        wr1(4'h6, 8'h40); wr1(4'h7, 8'h00);
        wr1(4'hB, 8'h03);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq%0d_count", i), 32'(ch_set_count), 32'(1 << i));
            check($sformatf("seq%0d_data", i), 32'(ch_data), 32'((i + 1) * 16));
            check($sformatf("seq%0d_ready", i), 32'(bus.wr_ready), 32'h0);
            check($sformatf("seq%0d_en", i), 32'(ch_enable), 32'h0);
            if (i == 1) rd1("seq_status", 4'hC, 8'h01);
            step();
        end
        check("done_count", 32'(ch_set_count), 32'h0);
        check("done_ready", 32'(bus.wr_ready), 32'h0);
        check("done_en", 32'(ch_enable), 32'h0);
        step();
        check("post_ready", 32'(bus.wr_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_en_%0d", k), 32'(ch_enable), (k == 3) ? 32'h5 : 32'h0);
            step();
        end

        // Write held across a restart is accepted exactly once
        wr1(4'hB, 8'h01);
        bus.wr = 1'b1; bus.wr_addr = 4'h3; bus.wr_data = 8'hAB;
        n = 0;
        latch_seen = 0;
        while (!bus.wr_ready && n < 20) begin
            if (ch_set_latch != 0) latch_seen++;
            step();
            n++;
        end
        check("hold_wait_cycles", 32'(n), 32'd5);
        check("hold_no_latch", 32'(latch_seen), 32'd0);
        step();
        bus.wr = 1'b0;
        check("hold_latch", 32'(ch_set_latch), 32'h2);
        check("hold_data", 32'(ch_data), 32'hAB40);
        step();
        check("hold_once", 32'(ch_set_latch), 32'h0);
        rd1("hold_rd_hi", 4'h3, 8'hAB);
        rd1("hold_rd_lo", 4'h2, 8'h40);

        // Reset during SEQ(1)
        wr1(4'hB, 8'h01);
        step();
        check("seq1_count", 32'(ch_set_count), 32'h2);
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(ch_set_count), 32'h0);
        check("arst_ready", 32'(bus.wr_ready), 32'h1);
        check("arst_data", 32'(ch_data), 32'h0);
        @(posedge clock); #1 reset_n = 1'b1;
        step();
        rd1("arst_mask", 4'h8, 8'h00);
        rd1("arst_pre_lo", 4'h9, 8'h00);
        rd1("arst_pre_hi", 4'hA, 8'h00);
        rd1("arst_status", 4'hC, 8'h00);

        // Unmapped address
        wr1(4'hD, 8'hFF);
        check("unmap_latch", 32'(ch_set_latch), 32'h0);
        check("unmap_count", 32'(ch_set_count), 32'h0);
        check("unmap_data", 32'(ch_data), 32'h0);
        rd1("unmap_rd_d", 4'hD, 8'h00);
        rd1("unmap_rd_mask", 4'h8, 8'h00);
        rd1("rd_cmd_zero", 4'hB, 8'h00);

        // Channel beyond NUM_CH=2
        wr2(4'h6, 8'h11);
        wr2(4'h7, 8'h22);
        check("ch3_latch", 32'(ch_set_latch2), 32'h0);
        check("ch3_data", 32'(ch_data2), 32'h0);
        bus2.rd_addr = 4'h7; #1;
        check("ch3_rd_hi", 32'(bus2.rd_data), 32'h0);
        bus2.rd_addr = 4'h6; #1;
        check("ch3_rd_lo", 32'(bus2.rd_data), 32'h0);
        wr2(4'h3, 8'h99);
        check("ch1_latch", 32'(ch_set_latch2), 32'h2);
        check("ch1_data", 32'(ch_data2), 32'h9911);
        bus2.rd_addr = 4'h3; #1;
        check("ch1_rd_hi", 32'(bus2.rd_data), 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
